// File: rtl/apb_slv_pkg.sv
//----------------------------------------------------------------------------
// Module  : apb_slv_pkg
// Purpose : Shared types and constants for the APB4 completer memory.
//           Holds the FSM state type, APB bus widths and the helper that
//           forms the registered read-data response.
// Ports   : none (package)
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package apb_slv_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic {S_IDLE, S_ACCESS} apb_slv_st;

  // Only a good read returns memory contents; writes and errors return zero.
  function automatic logic [APB_DATA_W-1:0] rsp_data(
    input logic                  is_read,
    input logic                  err,
    input logic [APB_DATA_W-1:0] word
  );
    return (is_read && !err) ? word : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_slave_mem_sat_cnt16.sv
//----------------------------------------------------------------------------
// Module  : sat_cnt16
// Purpose : 16-bit up counter that sticks at 16'hFFFF.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low clear
//           i_inc  - count enable (one increment per cycle)
//           o_cnt  - current count
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module sat_cnt16
  import apb_slv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/apb_slave_mem.sv
//----------------------------------------------------------------------------
// Module  : apb_slave_mem
// Purpose : APB4 completer with a word-addressed unreset memory, per-transfer
//           programmable wait states, byte strobes, error response and
//           saturating good-transfer counters.
// Ports   : pclk, preset_n          - clock, async active-low reset
//           psel_i .. pprot_i       - APB4 request signals
//           wait_cfg_i              - wait states, sampled in setup
//           pready_o/prdata_o/pslverr_o - registered APB response
//           proto_err_o             - 1-cycle pulse on master protocol error
//           last_prot_o             - pprot of last completed transfer
//           wr_cnt_o / rd_cnt_o     - completed good writes / reads
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_DEPTH = 256
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [APB_ADDR_W-1:0] paddr_i,
  input  logic [APB_DATA_W-1:0] pwdata_i,
  input  logic [APB_STRB_W-1:0] pstrb_i,
  input  logic [2:0]            pprot_i,
  input  logic [3:0]            wait_cfg_i,
  output logic                  pready_o,
  output logic [APB_DATA_W-1:0] prdata_o,
  output logic                  pslverr_o,
  output logic                  proto_err_o,
  output logic [2:0]            last_prot_o,
  output logic [15:0]           wr_cnt_o,
  output logic [15:0]           rd_cnt_o
);

  localparam int          IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  logic [APB_DATA_W-1:0] r_mem [MEM_DEPTH];

  apb_slv_st             r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic [APB_DATA_W-1:0] r_wdata;
  logic [APB_STRB_W-1:0] r_strb;
  logic [2:0]            r_prot;
  logic                  r_err;
  logic [3:0]            r_wait;
  logic                  r_pready;
  logic [APB_DATA_W-1:0] r_prdata;
  logic                  r_pslverr;
  logic                  r_proto_err;
  logic [2:0]            r_last_prot;

  // Word offset from the base; the full width is kept so that addresses far
  // beyond the memory do not alias back into range.
  logic [29:0]      w_word;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic             w_held;
  logic             w_done;
  logic             w_mem_we;

  assign w_word = paddr_i[31:2] - BASE_WORD;
  assign w_err  = (paddr_i[1:0] != 2'b00) || (paddr_i < BASE_ADDR) ||
                  (w_word >= 30'(MEM_DEPTH));
  assign w_idx  = w_word[IDX_W-1:0];

  assign w_held   = psel_i && penable_i;
  assign w_done   = (r_state == S_ACCESS) && w_held && r_pready;
  assign w_mem_we = w_done && r_write && !r_err;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_prot      <= '0;
      r_err       <= 1'b0;
      r_wait      <= '0;
      r_pready    <= 1'b0;
      r_prdata    <= '0;
      r_pslverr   <= 1'b0;
      r_proto_err <= 1'b0;
      r_last_prot <= '0;
    end else begin
      r_proto_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (psel_i && !penable_i) begin
            r_idx   <= w_idx;
            r_write <= pwrite_i;
            r_wdata <= pwdata_i;
            r_strb  <= pstrb_i;
            r_prot  <= pprot_i;
            r_err   <= w_err;
            r_wait  <= wait_cfg_i;
            r_state <= S_ACCESS;
            // Zero-wait transfers present the response in the first access cycle.
            if (wait_cfg_i == 4'd0) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= rsp_data(!pwrite_i, w_err, r_mem[w_idx]);
            end
          end else if (penable_i) begin
            r_proto_err <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (!w_held) begin
            // Master abandoned the access: drop the response, commit nothing.
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
            r_proto_err <= 1'b1;
            r_state     <= S_IDLE;
          end else if (r_pready) begin
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
            r_last_prot <= r_prot;
            r_state     <= S_IDLE;
          end else if (r_wait > 4'd1) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            r_wait    <= r_wait - 4'd1;
            r_pready  <= 1'b1;
            r_pslverr <= r_err;
            r_prdata  <= rsp_data(!r_write, r_err, r_mem[r_idx]);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory has no reset so its contents survive preset_n.
  always_ff @(posedge pclk) begin
    if (w_mem_we) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (r_strb[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  sat_cnt16 u_wr_cnt (
    .clk   (pclk),
    .rst_n (preset_n),
    .i_inc (w_done && r_write && !r_err),
    .o_cnt (wr_cnt_o)
  );

  sat_cnt16 u_rd_cnt (
    .clk   (pclk),
    .rst_n (preset_n),
    .i_inc (w_done && !r_write && !r_err),
    .o_cnt (rd_cnt_o)
  );

  assign pready_o    = r_pready;
  assign prdata_o    = r_prdata;
  assign pslverr_o   = r_pslverr;
  assign proto_err_o = r_proto_err;
  assign last_prot_o = r_last_prot;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
//----------------------------------------------------------------------------
// Module  : tb_apb_slave_mem
// Purpose : Self-checking bench for apb_slave_mem against a word-array model.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_apb_slave_mem;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 256;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] paddr_i, pwdata_i;
  logic [3:0]  pstrb_i;
  logic [2:0]  pprot_i;
  logic [3:0]  wait_cfg_i;
  logic        pready_o, pslverr_o, proto_err_o;
  logic [31:0] prdata_o;
  logic [2:0]  last_prot_o;
  logic [15:0] wr_cnt_o, rd_cnt_o;

  apb_slave_mem #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH)) dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .psel_i      (psel_i),
    .penable_i   (penable_i),
    .pwrite_i    (pwrite_i),
    .paddr_i     (paddr_i),
    .pwdata_i    (pwdata_i),
    .pstrb_i     (pstrb_i),
    .pprot_i     (pprot_i),
    .wait_cfg_i  (wait_cfg_i),
    .pready_o    (pready_o),
    .prdata_o    (prdata_o),
    .pslverr_o   (pslverr_o),
    .proto_err_o (proto_err_o),
    .last_prot_o (last_prot_o),
    .wr_cnt_o    (wr_cnt_o),
    .rd_cnt_o    (rd_cnt_o)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [DEPTH];
  int          exp_wr   = 0;
  int          exp_rd   = 0;
  logic [2:0]  exp_prot = 3'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    longint off;
    if (a % 4 != 0) return 1'b1;
    if (a < BASE) return 1'b1;
    off = (longint'(a) - longint'(BASE)) / 4;
    return off >= DEPTH;
  endfunction

  task automatic check_status(input string tag);
    chk({tag, ".last_prot"}, 32'(last_prot_o), 32'(exp_prot));
    chk({tag, ".wr_cnt"}, 32'(wr_cnt_o), 32'(exp_wr));
    chk({tag, ".rd_cnt"}, 32'(rd_cnt_o), 32'(exp_rd));
  endtask

  // Called #1 after a rising edge; returns #1 after the completing edge.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot, input int nwait,
                      input string tag, output logic [31:0] rd_obs);
    bit          err;
    int          widx;
    int          waits;
    logic [31:0] exp_rdata;
    err       = addr_bad(addr);
    widx      = int'((addr - BASE) >> 2);
    exp_rdata = (!wr && !err) ? mdl[widx] : 32'h0;

    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr;
    pwdata_i = data; pstrb_i = strb; pprot_i = prot; wait_cfg_i = 4'(nwait);
    @(posedge pclk); #1;
    penable_i = 1'b1;
    waits = 0;
    while (pready_o !== 1'b1 && waits < 40) begin
      @(posedge pclk); #1;
      waits++;
    end
    rd_obs = prdata_o;
    chk({tag, ".waits"}, 32'(waits), 32'(nwait));
    chk({tag, ".pslverr"}, 32'(pslverr_o), 32'(err));
    chk({tag, ".prdata"}, prdata_o, exp_rdata);
    @(posedge pclk); #1;
    psel_i = 1'b0; penable_i = 1'b0;
    chk({tag, ".pready_clr"}, 32'(pready_o), 32'd0);

    if (!err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) mdl[widx][8*b +: 8] = data[8*b +: 8];
        if (exp_wr < 65535) exp_wr++;
      end else begin
        if (exp_rd < 65535) exp_rd++;
      end
    end
    exp_prot = prot;
    check_status(tag);
  endtask

  // Starts an access that the caller will interrupt; returns #1 after the
  // second access edge.
  task automatic start_long_write(input logic [31:0] addr, input logic [31:0] data);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = addr;
    pwdata_i = data; pstrb_i = 4'hF; pprot_i = 3'd5; wait_cfg_i = 4'd5;
    @(posedge pclk); #1;
    penable_i = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] addr;
    bit          wr;

    preset_n = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0; pprot_i = '0; wait_cfg_i = '0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst.pready", 32'(pready_o), 32'd0);
    chk("rst.prdata", prdata_o, 32'd0);
    chk("rst.pslverr", 32'(pslverr_o), 32'd0);
    chk("rst.proto_err", 32'(proto_err_o), 32'd0);
    check_status("rst");
    preset_n = 1'b1;
    @(posedge pclk); #1;

    // Basic write then read
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'd1, 0, "t1.wr", rd);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'd2, 0, "t1.rd", rd);
    chk("t1.rd_const", rd, 32'hDEAD_BEEF);

    // Byte strobes
    xfer(1'b1, 32'h20, 32'h1122_3344, 4'hF, 3'd0, 1, "t2.wr0", rd);
    xfer(1'b1, 32'h20, 32'hAAAA_AAAA, 4'b0101, 3'd3, 2, "t2.wr1", rd);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'd4, 0, "t2.rd", rd);
    chk("t2.rd_const", rd, 32'h11AA_33AA);

    // Three wait states
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'd6, 3, "t3.rd", rd);

    // Error responses
    xfer(1'b0, 32'h402, 32'h0, 4'h0, 3'd7, 0, "t4.mis", rd);
    xfer(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, 3'd1, 1, "t4.oor", rd);

    // Fill words 0..15 so every later read has defined data
    for (int i = 0; i < 16; i++)
      xfer(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 3'($urandom_range(0, 7)),
           int'($urandom_range(0, 2)), "fill", rd);

    // Errored write leaves memory untouched
    xfer(1'b1, 32'h402, 32'hFFFF_FFFF, 4'hF, 3'd2, 1, "t5.errwr", rd);
    for (int i = 0; i < 16; i++)
      xfer(1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, 3'd0, 0, "t5.chk", rd);

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0)
          addr = BASE + 32'(4 * DEPTH) + ($urandom_range(0, 15) << 2);
        else
          addr = BASE + 32'(4 * $urandom_range(0, 15)) + $urandom_range(1, 3);
      end else begin
        addr = BASE + 32'(4 * $urandom_range(0, 15));
      end
      xfer(wr, addr, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
           int'($urandom_range(0, 4)), "rnd", rd);
    end

    // Master drops psel during a 5-wait write
    start_long_write(32'h08, 32'h5555_0000);
    psel_i = 1'b0; penable_i = 1'b0;
    @(posedge pclk); #1;
    chk("t6.proto_pulse", 32'(proto_err_o), 32'd1);
    chk("t6.pready", 32'(pready_o), 32'd0);
    @(posedge pclk); #1;
    chk("t6.proto_end", 32'(proto_err_o), 32'd0);
    check_status("t6");
    xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'd3, 1, "t6.rd", rd);

    // penable without setup while idle
    penable_i = 1'b1;
    @(posedge pclk); #1;
    chk("t7.proto_pulse", 32'(proto_err_o), 32'd1);
    penable_i = 1'b0;
    @(posedge pclk); #1;
    chk("t7.proto_end", 32'(proto_err_o), 32'd0);

    // Reset during the wait phase of a write
    start_long_write(32'h30, 32'hCAFE_F00D);
    preset_n = 1'b0;
    #1;
    exp_wr = 0; exp_rd = 0; exp_prot = 3'd0;
    chk("t8.pready", 32'(pready_o), 32'd0);
    chk("t8.prdata", prdata_o, 32'd0);
    chk("t8.pslverr", 32'(pslverr_o), 32'd0);
    check_status("t8");
    psel_i = 1'b0; penable_i = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    @(posedge pclk); #1;
    xfer(1'b0, 32'h30, 32'h0, 4'h0, 3'd2, 0, "t8.rd", rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
